// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and defaults for the data-memory arbiter
package dmem_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   localparam int MAX_STALL_DEF = 4;
   localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// rtl/dmem_arbiter_sat_counter.sv - saturating event counter
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the DataMEM port between the CPU MEM stage and a DMA port
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_STALL = MAX_STALL_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [AW-1:0]    m0_addr,
   input  logic [DW-1:0]    m0_wdata,
   output logic [DW-1:0]    m0_rdata,
   output logic             m0_stall,
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic             m1_lock,
   input  logic [AW-1:0]    m1_addr,
   input  logic [DW-1:0]    m1_wdata,
   output logic [DW-1:0]    m1_rdata,
   output logic             m1_ack,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   output logic             mem_re,
   output logic             mem_we,
   input  logic [DW-1:0]    mem_rdata,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int HW = $clog2(MAX_STALL + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_STALL);

   arb_state_t    state, state_next;
   logic          last_q;
   logic [HW-1:0] hold_q;
   logic          gnt0, gnt1;
   logic          stall0;

   // Starvation override outranks the burst lock, which outranks round-robin.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!reset) begin
         if (m0_req && (hold_q == HOLD_MAX)) begin
            gnt0 = 1'b1;
         end else if ((state == LOCKED) && m1_req) begin
            gnt1 = 1'b1;
         end else if (m0_req && !m1_req) begin
            gnt0 = 1'b1;
         end else if (m1_req && !m0_req) begin
            gnt1 = 1'b1;
         end else if (m0_req && m1_req) begin
            if (last_q == OWN_CPU) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end
      end
   end

   always_comb begin
      mem_addr  = '0;
      mem_wdata = '0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      if (gnt0) begin
         mem_addr  = m0_addr;
         mem_wdata = m0_wdata;
         mem_re    = ~m0_we;
         mem_we    = m0_we;
      end else if (gnt1) begin
         mem_addr  = m1_addr;
         mem_wdata = m1_wdata;
         mem_re    = ~m1_we;
         mem_we    = m1_we;
      end
   end

   assign stall0   = m0_req & ~gnt0 & ~reset;
   assign m0_stall = stall0;
   assign m1_ack   = gnt1;
   assign m0_rdata = reset ? '0 : mem_rdata;
   assign m1_rdata = reset ? '0 : mem_rdata;

   // A CPU override while LOCKED keeps the lock so the burst resumes next cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (gnt1 && m1_lock) begin
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (!m1_req || (gnt1 && !m1_lock)) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         last_q <= OWN_DMA;
         hold_q <= '0;
      end else begin
         state <= state_next;
         if (gnt0) begin
            last_q <= OWN_CPU;
         end else if (gnt1) begin
            last_q <= OWN_DMA;
         end
         if (stall0) begin
            hold_q <= (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
         end else begin
            hold_q <= '0;
         end
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_stall_cnt (
      .clk  (clk),
      .reset(reset),
      .inc  (stall0),
      .count(stall_cnt)
   );

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data-memory port (DataMEM, memory-mapped LEDs/display at 0x4000xxxx) between two requesters: the pipeline MEM stage (master 0, CPU) and a loader/debug DMA port (master 1).
- Grant is decided combinationally each cycle; registered state holds round-robin history, burst lock and anti-starvation counter.
- The CPU loses only by stalling: m0_stall drives the pipeline's global stall (PC, IF/ID, ID/EX, EX/MEM hold).
- Memory read is combinational and write happens at the clk edge, so a granted transfer completes in the same cycle.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_STALL, 4, consecutive CPU stall cycles after which the CPU wins the next conflict, overriding lock and round-robin (>=1)
CNT_W, 16, width of saturating CPU-stall statistics counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
m0_req  in  1  CPU access request (MemRead|MemWrite of MEM stage)
m0_we  in  1  CPU write enable
m0_addr  in  AW  CPU address
m0_wdata  in  DW  CPU write data
m0_rdata  out  DW  CPU read data, valid when m0_req & ~m0_stall
m0_stall  out  1  CPU must hold MEM stage this cycle
m1_req  in  1  DMA request
m1_we  in  1  DMA write enable
m1_lock  in  1  DMA burst lock, sampled with m1_req
m1_addr  in  AW  DMA address
m1_wdata  in  DW  DMA write data
m1_rdata  out  DW  DMA read data, valid when m1_ack
m1_ack  out  1  DMA transfer completes this cycle
mem_addr  out  AW  to DataMEM Address
mem_wdata  out  DW  to DataMEM write data
mem_re  out  1  to DataMEM MemRead
mem_we  out  1  to DataMEM MemWrite
mem_rdata  in  DW  from DataMEM read data
stall_cnt  out  CNT_W  saturating count of cycles with m0_stall=1

Behaviour:
Registered state, all cleared on reset:
- last_q: 1 bit; 0=CPU was last owner. Reset value 1, so the CPU wins the first conflict.
- state: IDLE or LOCKED.
- hold_q: 0..MAX_STALL.
- stall_cnt: reset value 0.

Grant (combinational, computed in priority order):
1. reset=1: no grant. m0_stall=0, m1_ack=0, mem_we=0, mem_re=0; mem_addr/mem_wdata/rdata outputs are 0.
2. m0_req & hold_q==MAX_STALL: grant CPU.
3. state==LOCKED & m1_req: grant DMA.
4. Only one request: grant that requester.
5. Both requesting: grant ~last_q (alternate owners).
6. No request: idle; mem_we=0, mem_re=0, mem_addr=0.

Outputs:
- Mux drives mem_* from the granted master; mem_re = granted & ~we; mem_we = granted & we.
- mem_rdata fans out to both m0_rdata and m1_rdata.
- m0_stall = m0_req & ~gnt0; m1_ack = gnt1.

Next-state (at clk edge):
- last_q <= owner whenever a grant occurs; otherwise unchanged.
- IDLE -> LOCKED when gnt1 & m1_lock.
- LOCKED -> IDLE when ~m1_req, or gnt1 & ~m1_lock (last beat of burst).
- A CPU override (rule 2) does not leave LOCKED; the burst resumes the next cycle.
- hold_q <= m0_stall ? min(hold_q+1, MAX_STALL) : 0.
- stall_cnt <= stall_cnt + m0_stall, saturating at all-ones.

Boundaries:
- Reset mid-burst: LOCKED cleared, no memory write during the reset cycle, DMA must re-request.
- m1_req drop while LOCKED: lock released in the same cycle (rule 3 not met), so a waiting CPU is granted that cycle.
- Address 0x40000010 display writes are not special-cased; the finish override stays outside this block.

Decomposition:
- Shared package dmem_arb_pkg holds: the state enum (IDLE, LOCKED); owner encoding (OWN_CPU=0, OWN_DMA=1); default MAX_STALL and CNT_W constants.
- One natural sub-module, sat_counter (parameter W, inputs clk/reset/inc, output count), used for stall_cnt.
- The grant mux stays inline.

Test Plan:
1. Only m0 reads: m0_req=1, m0_we=0, m0_addr=0x10, mem returns 0xDEADBEEF -> same cycle mem_addr=0x10, mem_re=1, m0_rdata=0xDEADBEEF, m0_stall=0.
2. First cycle after reset, both request (no lock), held for 4 cycles -> grants CPU, DMA, CPU, DMA; m0_stall=0,1,0,1; stall_cnt ends at 2.
3. DMA locked burst of 8 writes (m1_lock=1 until last beat), CPU requests one write from burst cycle 1 -> CPU stalls cycles 1-4, granted cycle 5; burst beats land in cycles 1-4 and 6-9; state IDLE after cycle 9.
4. Reset asserted at burst beat 3 for one cycle -> mem_we=0 that cycle, state=IDLE, hold_q=0, stall_cnt=0; the next DMA request without lock is arbitrated normally.
5. LOCKED with CPU waiting, DMA drops m1_req -> CPU granted the same cycle, m0_stall=0, state IDLE next cycle.
6. CNT_W=4, 20 CPU stall cycles -> stall_cnt saturates at 15 and stays 15.
